// File: rtl/spi_ram_burst.sv
// spi_ram_burst
//   Command-decoded single-port RAM behind the SPI slave front end. It consumes
//   {cmd[1:0], payload} words qualified by rx_valid, and keeps separate write
//   and read pointers that can auto-increment for burst transfers. Read data
//   waits in a one-entry output slot under a tx_valid/tx_ready handshake.
//
//   cmd 00 : set write pointer (range checked, addr_err on violation)
//   cmd 01 : write payload at write pointer
//   cmd 10 : set read pointer (range checked, addr_err on violation)
//   cmd 11 : read into output slot (rd_drop if slot still occupied)
//
// Ports
//   CLK       rising-edge clock
//   RST       synchronous active-low reset
//   din       {cmd, payload} command word
//   rx_valid  din valid this cycle
//   dout      read data, stable while tx_valid
//   tx_valid  dout holds unconsumed data
//   tx_ready  consumer takes dout when tx_valid && tx_ready
//   addr_err  one-cycle pulse: out-of-range set-address payload
//   rd_drop   one-cycle pulse: read discarded because slot was occupied
module spi_ram_burst #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter bit          AUTO_INC   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  addr_err,
  output logic                  rd_drop
);

  typedef enum logic [1:0] {
    CMD_SET_WA = 2'b00,
    CMD_WRITE  = 2'b01,
    CMD_SET_RA = 2'b10,
    CMD_READ   = 2'b11
  } cmd_e;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  // One bit wider than the payload so MEM_DEPTH == 2**DATA_WIDTH still fits.
  // A full-width compare also covers the "upper payload bits are zero" rule.
  localparam logic [DATA_WIDTH:0]   DEPTH_LIM = (DATA_WIDTH + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  slot_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  addr_err_q, addr_err_d;
  logic                  rd_drop_q, rd_drop_d;
  logic                  mem_we;

  cmd_e                  cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic [ADDR_WIDTH-1:0] payload_addr;
  logic                  in_range;
  logic                  slot_free;

  assign cmd          = cmd_e'(din[DATA_WIDTH+1:DATA_WIDTH]);
  assign payload      = din[DATA_WIDTH-1:0];
  assign payload_addr = payload[ADDR_WIDTH-1:0];
  assign in_range     = {1'b0, payload} < DEPTH_LIM;
  // Slot can take new data if empty or being drained this very cycle.
  assign slot_free    = (state_q == S_EMPTY) || tx_ready;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    addr_err_d = 1'b0;
    rd_drop_d  = 1'b0;
    mem_we     = 1'b0;

    if (state_q == S_FULL && tx_ready) begin
      state_d = S_EMPTY;
    end

    if (rx_valid) begin
      case (cmd)
        CMD_SET_WA: begin
          if (in_range) wr_ptr_d = payload_addr;
          else          addr_err_d = 1'b1;
        end
        CMD_WRITE: begin
          mem_we = 1'b1;
          if (AUTO_INC) wr_ptr_d = next_addr(wr_ptr_q);
        end
        CMD_SET_RA: begin
          if (in_range) rd_ptr_d = payload_addr;
          else          addr_err_d = 1'b1;
        end
        CMD_READ: begin
          if (slot_free) begin
            // Overrides the drain above: accept and reload in the same cycle.
            state_d = S_FULL;
            dout_d  = mem[rd_ptr_q];
            if (AUTO_INC) rd_ptr_d = next_addr(rd_ptr_q);
          end else begin
            rd_drop_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      addr_err_q <= 1'b0;
      rd_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      addr_err_q <= addr_err_d;
      rd_drop_q  <= rd_drop_d;
    end
  end

  // Storage has no reset; only writes are suppressed while RST is low.
  always_ff @(posedge CLK) begin
    if (RST && mem_we) begin
      mem[wr_ptr_q] <= payload;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = (state_q == S_FULL);
  assign addr_err = addr_err_q;
  assign rd_drop  = rd_drop_q;

endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised command-decoded single-port RAM that sits behind the SPI slave front end, consuming the same `{cmd[1:0], payload}` words the serial-to-parallel converter emits on `rx_valid`. Compared with the fixed 8-bit, 256-entry RAM it replaces, it is generic in data width, address width and depth. It auto-increments its write and read pointers for burst transfers, holds read data under a `tx_valid`/`tx_ready` handshake, and flags out-of-range addresses and dropped reads.

## Interface
- `DATA_WIDTH`, 8, payload and memory word width; must be ≥ `ADDR_WIDTH`.
- `ADDR_WIDTH`, 8, pointer width.
- `MEM_DEPTH`, 256, number of words; must be ≤ 2^`ADDR_WIDTH`.
- `AUTO_INC`, 1, when 1 the pointer advances after each data write/read; when 0 pointers are static.
- `CLK` input 1, single clock, all logic on rising edge.
- `RST` input 1, synchronous, active-low reset.
- `din` input `DATA_WIDTH+2`, command word: `din[DATA_WIDTH+1:DATA_WIDTH]` = cmd, `din[DATA_WIDTH-1:0]` = payload.
- `rx_valid` input 1, `din` is valid this cycle; one command is consumed per asserted cycle.
- `dout` output `DATA_WIDTH`, read data, stable while `tx_valid`=1.
- `tx_valid` output 1, `dout` holds unconsumed read data.
- `tx_ready` input 1, consumer accepts `dout` on a cycle where `tx_valid`=1 and `tx_ready`=1.
- `addr_err` output 1, one-cycle pulse: a set-address payload was ≥ `MEM_DEPTH`.
- `rd_drop` output 1, one-cycle pulse: a read command was discarded because the output was still occupied.

## Operation
- Commands are decoded only when `rx_valid`=1; otherwise all state holds.
  - cmd 00, set write address: if `payload[ADDR_WIDTH-1:0]` < `MEM_DEPTH` and the upper payload bits are 0, `wr_ptr` ← payload; otherwise `wr_ptr` is unchanged and `addr_err` pulses.
  - cmd 01, write data: `mem[wr_ptr]` ← payload. If `AUTO_INC`, `wr_ptr` ← `wr_ptr`+1, wrapping from `MEM_DEPTH-1` to 0.
  - cmd 10, set read address: same range check as cmd 00, applied to `rd_ptr`.
  - cmd 11, read. Accepted if the output slot is free (`tx_valid`=0) or being freed this cycle (`tx_valid`=1 and `tx_ready`=1).
    - On accept: `dout` ← `mem[rd_ptr]`, `tx_valid` ← 1, and `rd_ptr` increments with wrap if `AUTO_INC`.
    - On reject: `rd_drop` pulses; `rd_ptr`, `dout` and `tx_valid` are unchanged.
- Output slot FSM:
  - EMPTY (`tx_valid`=0) → FULL on an accepted read.
  - FULL → EMPTY when `tx_ready`=1 and there is no accepted read.
  - FULL → FULL (new data loaded) when `tx_ready`=1 and a read is accepted in the same cycle.
  - FULL holds while `tx_ready`=0.
- Memory contents are not initialised and are not touched by reset.
- Reset (`RST`=0 at a clock edge) sets:
  - `wr_ptr`=0, `rd_ptr`=0;
  - `tx_valid`=0, `dout`=0;
  - `addr_err`=0, `rd_drop`=0.

  Reset during FULL discards the pending data. `rx_valid` is ignored while `RST`=0.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Write: memory is updated at the edge that samples cmd 01. A read command on the next cycle returns the new value.
- Read latency is 1 cycle: cmd 11 sampled at edge N gives `dout`/`tx_valid` valid after edge N.
- Maximum throughput is one read per cycle, provided `tx_ready` stays 1.
- `addr_err` and `rd_drop` are high for exactly the one cycle following the offending command.
- `tx_ready` has no effect while `tx_valid`=0.

## Test plan
- **Reset:** drive `RST`=0 for 2 cycles with `rx_valid`=1 and cmd 11 → `tx_valid`=0, `dout`=0, no pulses; pointers read back as 0.
- **Burst write/read:**
  - Stimulus: cmd 00/payload 0x10, cmd 01 with 0xA1, 0xB2, 0xC3, then cmd 10/0x10, then three cmd 11 with `tx_ready`=1.
  - Response: `dout` = 0xA1, 0xB2, 0xC3 on consecutive cycles, and `tx_valid` stays 1 throughout.
- **Wrap-around:**
  - Config: `MEM_DEPTH`=200.
  - Stimulus: cmd 00/199, write 0x55, write 0x66; cmd 10/199, two reads.
  - Response: reads return 0x55 then 0x66, and `mem[0]`=0x66.
- **Range error:**
  - Config: `MEM_DEPTH`=200.
  - Stimulus: cmd 00/0xC8.
  - Response: `addr_err` pulses for 1 cycle and `wr_ptr` keeps its previous value. Repeat with cmd 10 for the same result on `rd_ptr`.
- **Backpressure:**
  - Stimulus: with `tx_ready`=0, read `mem[5]`=0x3C, then issue a second cmd 11.
  - Response: `rd_drop` pulses, `dout` stays 0x3C, and `rd_ptr`=6. Raising `tx_ready` for 1 cycle then clears `tx_valid`.
- **Simultaneous accept and read:**
  - Stimulus: while FULL, assert `tx_ready`=1 together with cmd 11.
  - Response: no `rd_drop`, `tx_valid` stays 1, and `dout` updates to the next word. Follow with `RST`=0 while FULL → `tx_valid`=0.
